pwm_timebase_multi: RTL

Parametrised PWM timebase with one shared up-counter and N_CH compare channels. Replaces the fixed modulo-1000 counter and 1 kHz divider.
- Period is programmable at runtime.
- Per-channel duty values are double-buffered, so updates take effect only at a period boundary (glitch-free).
- Sits between the motor-control FSM, which writes duty and period, and the motor driver pins.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_timebase_multi_compare_ch.sv | 63 ++++++
 rtl/pwm_timebase_multi.sv | 107 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM timebase.
// Holds the timebase FSM encoding and the minimum-period clamp helper.
// Optional feature macro used by the PWM files: PWM_POLARITY_EN.
package pwm_pkg;

  localparam int STATE_W = 2;

  // Fixed encodings keep the state register compatible with older captures.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // A period of one clock cannot produce a wrap plus a half-period event,
  // so a requested period_m1 of 0 is promoted to 1 (two clocks minimum).
  function automatic logic [31:0] clamp_period_m1(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/pwm_timebase_multi_compare_ch.sv
// pwm_compare_ch: one PWM channel of the timebase.
// Double-buffered duty (shadow written by the host, active loaded at the
// period boundary) feeding a registered compare against the shared counter.
// With PWM_POLARITY_EN defined, a per-channel polarity bit is buffered the
// same way and sets both the output inversion and the idle level.
module pwm_compare_ch #(
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_duty,
  input  logic [CNT_W-1:0] i_counter,
`ifdef PWM_POLARITY_EN
  input  logic             i_polarity,
`endif
  output logic             o_pwm
);

  logic [CNT_W-1:0] duty_shadow;
  logic [CNT_W-1:0] duty_active;
  logic             pol_active;

`ifdef PWM_POLARITY_EN
  logic pol_shadow;

  // Polarity shadow captured on host write
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   pol_shadow <= 1'b0;
    else if (i_wr) pol_shadow <= i_polarity;
  end

  // Polarity becomes active together with duty at LOAD and at wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     pol_active <= 1'b0;
    else if (i_load) pol_active <= pol_shadow;
  end
`else
  assign pol_active = 1'b0;
`endif

  // Duty shadow captured on host write
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   duty_shadow <= '0;
    else if (i_wr) duty_shadow <= i_duty;
  end

  // Active duty only changes at a period boundary, so no glitches mid-period
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     duty_active <= '0;
    else if (i_load) duty_active <= duty_shadow;
  end

  // Registered compare; outside RUN the pin rests at its inactive level
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)    o_pwm <= 1'b0;
    else if (i_run) o_pwm <= (i_counter < duty_active) ^ pol_active;
    else            o_pwm <= pol_active;
  end

endmodule

// File: rtl/pwm_timebase_multi.sv
// pwm_timebase_multi: shared up-counter timebase with N_CH compare channels.
// Runtime-programmable period and per-channel duty, both double-buffered so
// host writes only take effect at the next period boundary. Also produces a
// one-cycle wrap tick and a divided clock toggling at half period and wrap.
// Optional feature: define PWM_POLARITY_EN to add per-channel polarity.
module pwm_timebase_multi
  import pwm_pkg::*;
#(
  parameter int CNT_W         = 10,
  parameter int N_CH          = 2,
  parameter int DEF_PERIOD_M1 = 999
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic [CNT_W-1:0]       i_period_m1,
  input  logic [N_CH*CNT_W-1:0]  i_duty,
  input  logic                   i_wr,
`ifdef PWM_POLARITY_EN
  input  logic [N_CH-1:0]        i_polarity,
`endif
  output logic [CNT_W-1:0]       o_counter,
  output logic                   o_tick,
  output logic                   o_clk_div,
  output logic [N_CH-1:0]        o_pwm
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD_M1);

  state_e           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period_shadow;
  logic [CNT_W-1:0] period_active;
  logic [CNT_W-1:0] period_wr;
  logic             running;
  logic             wrap;
  logic             load_active;

  assign running     = (state == ST_RUN) && i_en;
  assign wrap        = (state == ST_RUN) && (counter == period_active);
  // Shadow -> active transfer happens on entry to RUN and at every wrap
  assign load_active = i_en && ((state == ST_LOAD) || wrap);
  assign period_wr   = CNT_W'(clamp_period_m1(32'(i_period_m1)));

  assign o_counter = counter;
  assign o_tick    = wrap;

  // Run-control FSM: dropping i_en returns to IDLE from any state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)    state <= ST_IDLE;
    else if (!i_en) state <= ST_IDLE;
    else begin
      case (state)
        ST_IDLE: state <= ST_LOAD;
        ST_LOAD: state <= ST_RUN;
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Timebase counter: counts in RUN, returns to 0 at wrap and outside RUN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                counter <= '0;
    else if (running && !wrap)  counter <= counter + 1'b1;
    else                        counter <= '0;
  end

  // Period shadow captured on host write, with the minimum-period clamp
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   period_shadow <= DEF_P;
    else if (i_wr) period_shadow <= period_wr;
  end

  // Active period takes the pre-write shadow when a write coincides with wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)          period_active <= DEF_P;
    else if (load_active) period_active <= period_shadow;
  end

  // Divided clock: toggles after the half-period count and after the wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)       o_clk_div <= 1'b0;
    else if (!running) o_clk_div <= 1'b0;
    else if ((counter == (period_active >> 1)) || wrap)
      o_clk_div <= ~o_clk_div;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_compare_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_wr       (i_wr),
      .i_load     (load_active),
      .i_run      (running),
      .i_duty     (i_duty[k*CNT_W +: CNT_W]),
      .i_counter  (counter),
`ifdef PWM_POLARITY_EN
      .i_polarity (i_polarity[k]),
`endif
      .o_pwm      (o_pwm[k])
    );
  end

endmodule
